// File: rtl/mac_psum_sched.sv
// Sequencer for one MAC PE and its act/weight/psum register files: k-outer/p-inner issue loop with
// psum RAW bubbles. Optional perf counters are enabled by defining MAC_SCHED_PERF_EN.
module mac_psum_sched #(
    parameter int IN_ADDR_BITWIDTH   = 4,
    parameter int W_ADDR_BITWIDTH    = 6,
    parameter int PSUM_ADDR_BITWIDTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [PSUM_ADDR_BITWIDTH-1:0] cfg_psum_last,
    input  logic [IN_ADDR_BITWIDTH-1:0]   cfg_acc_last,
    input  logic                          stall,
    output logic                          busy,
    output logic                          done,
    output logic                          mac_en,
    output logic [IN_ADDR_BITWIDTH-1:0]   a_addr,
    output logic [W_ADDR_BITWIDTH-1:0]    w_addr,
    output logic [PSUM_ADDR_BITWIDTH-1:0] psum_addr,
    output logic                          sum_zero
`ifdef MAC_SCHED_PERF_EN
    ,
    output logic [15:0]                   perf_cycles,
    output logic [15:0]                   perf_stalls
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_BUBBLE = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                          state_q, state_d;
    logic [IN_ADDR_BITWIDTH-1:0]     k_q, k_d, acl_q, acl_d;
    logic [PSUM_ADDR_BITWIDTH-1:0]   p_q, p_d, psl_q, psl_d;
    logic [W_ADDR_BITWIDTH-1:0]      w_q, w_d;
    logic                            last_q, last_d;

    logic                            busy_q, busy_d, done_q, done_d, mac_en_q, mac_en_d;
    logic                            sum_zero_q, sum_zero_d;
    logic [IN_ADDR_BITWIDTH-1:0]     a_addr_q, a_addr_d;
    logic [W_ADDR_BITWIDTH-1:0]      w_addr_q, w_addr_d;
    logic [PSUM_ADDR_BITWIDTH-1:0]   psum_addr_q, psum_addr_d;

    logic                            is_last;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        p_d         = p_q;
        w_d         = w_q;
        acl_d       = acl_q;
        psl_d       = psl_q;
        last_d      = last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        mac_en_d    = 1'b0;
        sum_zero_d  = 1'b0;
        a_addr_d    = '0;
        w_addr_d    = '0;
        psum_addr_d = '0;
        is_last     = (k_q == acl_q) && (p_q == psl_q);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acl_d   = cfg_acc_last;
                    psl_d   = cfg_psum_last;
                    k_d     = '0;
                    p_d     = '0;
                    w_d     = '0;
                    last_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Addresses always present the pending op, so a stall shows it held with mac_en low.
                a_addr_d    = k_q;
                psum_addr_d = p_q;
                w_addr_d    = w_q;
                sum_zero_d  = (k_q == '0);
                if (!stall) begin
                    mac_en_d = 1'b1;
                    w_d      = w_q + 1'b1;
                    if (p_q == psl_q) begin
                        p_d = '0;
                        if (!is_last)
                            k_d = k_q + 1'b1;
                    end else begin
                        p_d = p_q + 1'b1;
                    end
                    if (psl_q == '0) begin
                        last_d  = is_last;
                        state_d = S_BUBBLE;
                    end else if (is_last) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_BUBBLE: begin
                a_addr_d    = k_q;
                psum_addr_d = p_q;
                w_addr_d    = w_q;
                sum_zero_d  = (k_q == '0);
                if (!stall)
                    state_d = last_q ? S_DRAIN : S_RUN;
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            p_q         <= '0;
            w_q         <= '0;
            acl_q       <= '0;
            psl_q       <= '0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mac_en_q    <= 1'b0;
            sum_zero_q  <= 1'b0;
            a_addr_q    <= '0;
            w_addr_q    <= '0;
            psum_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            p_q         <= p_d;
            w_q         <= w_d;
            acl_q       <= acl_d;
            psl_q       <= psl_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mac_en_q    <= mac_en_d;
            sum_zero_q  <= sum_zero_d;
            a_addr_q    <= a_addr_d;
            w_addr_q    <= w_addr_d;
            psum_addr_q <= psum_addr_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mac_en    = mac_en_q;
    assign a_addr    = a_addr_q;
    assign w_addr    = w_addr_q;
    assign psum_addr = psum_addr_q;
    assign sum_zero  = sum_zero_q;

`ifdef MAC_SCHED_PERF_EN
    logic [15:0] perf_cycles_q, perf_cycles_d, perf_stalls_q, perf_stalls_d;

    always_comb begin
        perf_cycles_d = perf_cycles_q;
        perf_stalls_d = perf_stalls_q;
        if (state_q == S_IDLE && start) begin
            perf_cycles_d = '0;
            perf_stalls_d = '0;
        end else begin
            if (busy_q && perf_cycles_q != 16'hFFFF)
                perf_cycles_d = perf_cycles_q + 16'd1;
            if ((state_q == S_RUN || state_q == S_BUBBLE) && stall && perf_stalls_q != 16'hFFFF)
                perf_stalls_d = perf_stalls_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            perf_cycles_q <= perf_cycles_d;
            perf_stalls_q <= perf_stalls_d;
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_stalls = perf_stalls_q;
`endif

endmodule
